// File: rtl/mpeg_pkg.sv
// Shared constants for the zigzag/quantizer block: coefficient widths, scan table, FSM states.
package mpeg_pkg;

    localparam int unsigned COEF_W  = 16;
    localparam int unsigned QCOEF_W = 12;
    localparam int unsigned N_COEF  = 64;

    typedef enum logic {StFill, StDrain} zq_state_e;

    // Raster address {u,v} read at each zigzag scan position.
    localparam logic [5:0] ZZ_TABLE [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

endpackage

// File: rtl/zq_quantizer.sv
// Combinational quantizer: shift by (u+v)>>1, optional round-half-up, saturate to QCOEF_W bits.
// Rounding is enabled by defining ZIGZAG_QUANT_ROUND_EN; default build truncates toward -inf.
module zq_quantizer
    import mpeg_pkg::*;
(
    input  logic [2:0]         coef_u,
    input  logic [2:0]         coef_v,
    input  logic [COEF_W-1:0]  coef_data,
    output logic [QCOEF_W-1:0] qcoef
);

    localparam logic signed [COEF_W:0] QMax = $signed((COEF_W+1)'((1 << (QCOEF_W-1)) - 1));
    localparam logic signed [COEF_W:0] QMin = ~QMax;

    logic [3:0]               uv_sum;
    logic [2:0]               shift;
    logic signed [COEF_W:0]   wide;
    logic signed [COEF_W:0]   shifted;

    always_comb begin
        uv_sum  = {1'b0, coef_u} + {1'b0, coef_v};
        shift   = uv_sum[3:1];
        wide    = $signed({coef_data[COEF_W-1], coef_data});
`ifdef ZIGZAG_QUANT_ROUND_EN
        if (shift != 3'd0) begin
            wide = wide + ((COEF_W+1)'(1) << (shift - 3'd1));
        end
`endif
        shifted = wide >>> shift;
        if (shifted > QMax) begin
            qcoef = QMax[QCOEF_W-1:0];
        end else if (shifted < QMin) begin
            qcoef = QMin[QCOEF_W-1:0];
        end else begin
            qcoef = shifted[QCOEF_W-1:0];
        end
    end

endmodule

// File: rtl/zigzag_quant.sv
// Collects one 8x8 block of quantized DCT coefficients, then drains it in zigzag order.
// Quantizer rounding is selected by ZIGZAG_QUANT_ROUND_EN (see zq_quantizer).
module zigzag_quant
    import mpeg_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               coef_valid,
    input  logic [2:0]         coef_u,
    input  logic [2:0]         coef_v,
    input  logic [COEF_W-1:0]  coef_data,
    input  logic               block_done,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [QCOEF_W-1:0] out_data,
    output logic [5:0]         out_index,
    output logic               out_last,
    output logic               busy,
    output logic               err
);

    zq_state_e state_q, state_d;

    logic [6:0]         cnt_q, cnt_d, cnt_wr;
    logic [5:0]         pos_q, pos_d;
    logic               out_valid_q, out_valid_d;
    logic [QCOEF_W-1:0] out_data_q, out_data_d;
    logic [5:0]         out_index_q, out_index_d;
    logic               out_last_q, out_last_d;
    logic               err_q, err_d;

    logic [QCOEF_W-1:0] mem [N_COEF];
    logic [QCOEF_W-1:0] qcoef;
    logic               wr_en;
    logic               load;
    logic               finish;

    zq_quantizer u_quant (
        .coef_u    (coef_u),
        .coef_v    (coef_v),
        .coef_data (coef_data),
        .qcoef     (qcoef)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFill;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFill:  if (block_done) state_d = StDrain;
            StDrain: if (finish)     state_d = StFill;
            default: state_d = StFill;
        endcase
    end

    always_comb begin
        busy = (state_q == StDrain);
    end

    always_comb begin
        wr_en  = (state_q == StFill) && coef_valid;
        cnt_wr = (wr_en && cnt_q != 7'd64) ? cnt_q + 7'd1 : cnt_q;
        finish = (state_q == StDrain) && out_valid_q && out_ready && out_last_q;
        // Fetch the next scan position when the output register is empty or being consumed.
        load   = (state_q == StDrain) && (!out_valid_q || out_ready) && !finish;

        cnt_d       = cnt_wr;
        pos_d       = pos_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        err_d       = err_q;

        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = mem[ZZ_TABLE[pos_q]];
            out_index_d = pos_q;
            out_last_d  = (pos_q == 6'd63);
            pos_d       = pos_q + 6'd1;
        end
        if (finish) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            cnt_d       = 7'd0;
            pos_d       = 6'd0;
        end

        if (state_q == StFill && block_done && cnt_wr != 7'd64) begin
            err_d = 1'b1;
        end
        if (state_q == StDrain && (coef_valid || block_done)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= 7'd0;
            pos_q       <= 6'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= 6'd0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            pos_q       <= pos_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
        end
    end

    // Coefficient store is deliberately not reset; stale entries persist across blocks.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{coef_u, coef_v}] <= qcoef;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;
    assign err       = err_q;

endmodule
